// File: rtl/muldiv_iter_if.sv
// ============================================================================
// Module   : muldiv_iter_if
// Brief    : Request/response handshake bundle for the iterative mul/div unit.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface muldiv_iter_if #(
  parameter int XLEN = 32
) ();
  logic            in_valid;
  logic            in_ready;
  logic [2:0]      funct3;
  logic [XLEN-1:0] rs1;
  logic [XLEN-1:0] rs2;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;

  modport master (
    output in_valid, funct3, rs1, rs2, out_ready,
    input  in_ready, out_valid, result
  );

  modport slave (
    input  in_valid, funct3, rs1, rs2, out_ready,
    output in_ready, out_valid, result
  );
endinterface

`default_nettype wire

// File: rtl/muldiv_iter.sv
// ============================================================================
// Module   : muldiv_iter
// Brief    : Iterative RV32M/RV64M multiply/divide (shift-add / restoring).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module muldiv_iter #(
  parameter int XLEN           = 32,
  parameter int BITS_PER_CYCLE = 1
) (
  input  wire logic      clk,
  input  wire logic      rst_n,
  input  wire logic      flush,
  output logic           busy,
  muldiv_iter_if.slave   bus
);

  localparam int              c_STEPS = XLEN / BITS_PER_CYCLE;
  localparam int              c_CNT_W = $clog2(c_STEPS) + 1;
  localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(c_STEPS - 1);
  localparam logic [XLEN-1:0] c_MIN   = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t              r_state;
  logic [2:0]          r_funct3;
  logic [XLEN-1:0]     r_b;
  logic                r_neg_a;
  logic                r_neg_b;
  logic [c_CNT_W-1:0]  r_step;
  logic [2*XLEN-1:0]   r_acc;
  logic [XLEN-1:0]     r_result;
  logic                r_out_valid;

  logic                w_signed_a;
  logic                w_signed_b;
  logic                w_neg_a_in;
  logic                w_neg_b_in;
  logic [XLEN-1:0]     w_abs_a;
  logic [XLEN-1:0]     w_abs_b;
  logic                w_div_zero;
  logic                w_div_ovf;
  logic [XLEN-1:0]     w_special_res;
  logic [2*XLEN-1:0]   w_acc_step;
  logic [2*XLEN:0]     w_sh;
  logic [XLEN:0]       w_sum;
  logic [2*XLEN-1:0]   w_prod;
  logic [XLEN-1:0]     w_quo;
  logic [XLEN-1:0]     w_rem;
  logic [XLEN-1:0]     w_fix_res;

  // Unsigned rs1 only for MULHU/DIVU/REMU; rs2 additionally unsigned for MULHSU.
  assign w_signed_a = !((bus.funct3 == 3'd3) || (bus.funct3[2] && bus.funct3[0]));
  assign w_signed_b = w_signed_a && (bus.funct3 != 3'd2);
  assign w_neg_a_in = w_signed_a && bus.rs1[XLEN-1];
  assign w_neg_b_in = w_signed_b && bus.rs2[XLEN-1];
  assign w_abs_a    = w_neg_a_in ? -bus.rs1 : bus.rs1;
  assign w_abs_b    = w_neg_b_in ? -bus.rs2 : bus.rs2;

  assign w_div_zero = bus.funct3[2] && (bus.rs2 == '0);
  assign w_div_ovf  = bus.funct3[2] && !bus.funct3[0] &&
                      (bus.rs1 == c_MIN) && (bus.rs2 == '1);

  always_comb begin
    w_special_res = '0;
    if (w_div_zero)
      w_special_res = bus.funct3[1] ? bus.rs1 : '1;
    else
      w_special_res = bus.funct3[1] ? '0 : c_MIN;
  end

  // Retire BITS_PER_CYCLE multiplier or quotient bits in one clock.
  always_comb begin
    w_acc_step = r_acc;
    w_sh       = '0;
    w_sum      = '0;
    for (int i = 0; i < BITS_PER_CYCLE; i++) begin
      if (r_funct3[2]) begin
        w_sh = {w_acc_step, 1'b0};
        if (w_sh[2*XLEN:XLEN] >= {1'b0, r_b}) begin
          w_sh[2*XLEN:XLEN] = w_sh[2*XLEN:XLEN] - {1'b0, r_b};
          w_sh[0]           = 1'b1;
        end
        w_acc_step = w_sh[2*XLEN-1:0];
      end else begin
        w_sum      = {1'b0, w_acc_step[2*XLEN-1:XLEN]} +
                     (w_acc_step[0] ? {1'b0, r_b} : {(XLEN+1){1'b0}});
        w_acc_step = {w_sum, w_acc_step[XLEN-1:1]};
      end
    end
  end

  assign w_prod = (r_neg_a ^ r_neg_b) ? -r_acc : r_acc;
  assign w_quo  = (r_neg_a ^ r_neg_b) ? -r_acc[XLEN-1:0] : r_acc[XLEN-1:0];
  assign w_rem  = r_neg_a ? -r_acc[2*XLEN-1:XLEN] : r_acc[2*XLEN-1:XLEN];

  always_comb begin
    w_fix_res = '0;
    case (r_funct3)
      3'd0:       w_fix_res = w_prod[XLEN-1:0];
      3'd1, 3'd2,
      3'd3:       w_fix_res = w_prod[2*XLEN-1:XLEN];
      3'd4, 3'd5: w_fix_res = w_quo;
      default:    w_fix_res = w_rem;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_funct3    <= '0;
      r_b         <= '0;
      r_neg_a     <= 1'b0;
      r_neg_b     <= 1'b0;
      r_step      <= '0;
      r_acc       <= '0;
      r_result    <= '0;
      r_out_valid <= 1'b0;
    end else if (flush) begin
      r_state     <= S_IDLE;
      r_out_valid <= 1'b0;
      r_step      <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.in_valid) begin
            r_funct3 <= bus.funct3;
            r_b      <= w_abs_b;
            r_neg_a  <= w_neg_a_in;
            r_neg_b  <= w_neg_b_in;
            // Both algorithms start from {zero, |rs1|}.
            r_acc    <= {{XLEN{1'b0}}, w_abs_a};
            r_step   <= '0;
            if (w_div_zero || w_div_ovf) begin
              r_result    <= w_special_res;
              r_out_valid <= 1'b1;
              r_state     <= S_DONE;
            end else begin
              r_state <= S_CALC;
            end
          end
        end
        S_CALC: begin
          r_acc  <= w_acc_step;
          r_step <= r_step + 1'b1;
          if (r_step == c_LAST) begin
            r_step  <= '0;
            r_state <= S_FIX;
          end
        end
        S_FIX: begin
          r_result    <= w_fix_res;
          r_out_valid <= 1'b1;
          r_state     <= S_DONE;
        end
        S_DONE: begin
          if (bus.out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (r_state == S_IDLE);
  assign bus.out_valid = r_out_valid;
  assign bus.result    = r_result;
  assign busy          = (r_state != S_IDLE);

endmodule

`default_nettype wire
